// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz raster timing from a 25 MHz pixel clock.
// hCount/vCount are the only timing state. Every output is decoded
// combinationally from those registers, so outputs describe the current
// counter state with zero latency.
// Optional build macro VGA_FRAME_COUNT_EN adds a 16-bit frame counter
// output (frameCount).
module vga_timing_gen #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk25,
  input  logic        reset,
  output logic        screenEnd,
  output logic        active,
  output logic        hSync,
  output logic        vSync,
  output logic [9:0]  x,
  output logic [8:0]  y
`ifdef VGA_FRAME_COUNT_EN
  , output logic [15:0] frameCount
`endif
);

  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

  // 10-bit decode constants so all compares are the same width as the counters
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(WIDTH);
  localparam logic [9:0] V_VIS  = 10'(HEIGHT);
  localparam logic [9:0] H_SS   = 10'(WIDTH + H_FP);
  localparam logic [9:0] H_SE   = 10'(WIDTH + H_FP + H_SYNC);
  localparam logic [9:0] V_SS   = 10'(HEIGHT + V_FP);
  localparam logic [9:0] V_SE   = 10'(HEIGHT + V_FP + V_SYNC);

  logic [9:0] hCount;
  logic [9:0] vCount;

  // Raster counters: hCount every cycle, vCount on each line wrap
  always_ff @(posedge clk25) begin
    if (!reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hCount == H_LAST) begin
      hCount <= '0;
      vCount <= (vCount == V_LAST) ? '0 : vCount + 10'd1;
    end else begin
      hCount <= hCount + 10'd1;
    end
  end

  // Output decode from registered counters only (screenEnd feeds an edge-sensitive consumer)
  always_comb begin
    active    = (hCount < H_VIS) && (vCount < V_VIS);
    x         = active ? hCount : '0;
    y         = active ? vCount[8:0] : '0;
    hSync     = !((hCount >= H_SS) && (hCount < H_SE));
    vSync     = !((vCount >= V_SS) && (vCount < V_SE));
    screenEnd = (hCount == '0) && (vCount == V_VIS);
  end

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter advances on the edge that closes the screenEnd cycle
  always_ff @(posedge clk25) begin
    if (!reset)         frameCount <= '0;
    else if (screenEnd) frameCount <= frameCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance A uses the real 640x480 timing for
// line-level checks; instance B uses a shrunken raster (80x55 total) so
// whole-frame behaviour fits in a short run. A cycle model pushes the
// expected outputs at every clock edge; they are popped and compared on
// the following falling edge.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, rstB;
  logic       seA, actA, hsA, vsA;
  logic [9:0] xA;
  logic [8:0] yA;
  logic       seB, actB, hsB, vsB;
  logic [9:0] xB;
  logic [8:0] yB;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fcA, fcB;
`endif

  int checks = 0;
  int errors = 0;

  vga_timing_gen dutA (
    .clk25(clk), .reset(rstA), .screenEnd(seA), .active(actA),
    .hSync(hsA), .vSync(vsA), .x(xA), .y(yA)
`ifdef VGA_FRAME_COUNT_EN
    , .frameCount(fcA)
`endif
  );

  vga_timing_gen #(
    .WIDTH(64), .HEIGHT(48), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dutB (
    .clk25(clk), .reset(rstB), .screenEnd(seB), .active(actB),
    .hSync(hsB), .vSync(vsB), .x(xB), .y(yB)
`ifdef VGA_FRAME_COUNT_EN
    , .frameCount(fcB)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected {screenEnd, active, hSync, vSync, x, y} from a linear frame position
  function automatic logic [31:0] expVec(int pos, int ht, int w, int h,
                                         int hss, int hse, int vss, int vse);
    int hc, vc;
    logic act;
    logic [9:0] ex;
    logic [8:0] ey;
    hc  = pos % ht;
    vc  = pos / ht;
    act = (hc < w) && (vc < h);
    ex  = act ? 10'(hc) : 10'd0;
    ey  = act ? 9'(vc) : 9'd0;
    return {9'd0, (hc == 0 && vc == h), act, !(hc >= hss && hc < hse),
            !(vc >= vss && vc < vse), ex, ey};
  endfunction

  typedef struct {
    logic [31:0] outs;
    logic [15:0] fc;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];
  int posA = 0, posB = 0, tB = 0;
  logic [15:0] fcmA = '0, fcmB = '0;

  // Model A: position within the 800x525 frame
  always @(posedge clk) begin
    exp_t e;
    if (!rstA) begin
      posA = 0; fcmA = '0;
    end else begin
      if (posA == 480 * 800) fcmA = fcmA + 16'd1;
      posA = (posA + 1) % (800 * 525);
    end
    e.outs = expVec(posA, 800, 640, 480, 656, 752, 490, 492);
    e.fc   = fcmA;
    qA.push_back(e);
  end

  // Model B: position within the 80x55 frame, tB = edges since reset release
  always @(posedge clk) begin
    exp_t e;
    if (!rstB) begin
      posB = 0; fcmB = '0; tB = 0;
    end else begin
      if (posB == 48 * 80) fcmB = fcmB + 16'd1;
      posB = (posB + 1) % (80 * 55);
      tB++;
    end
    e.outs = expVec(posB, 80, 64, 48, 68, 76, 50, 52);
    e.fc   = fcmB;
    qB.push_back(e);
  end

  // Per-cycle scoreboard compare
  always @(negedge clk) begin
    exp_t e;
    if (qA.size() > 0) begin
      e = qA.pop_front();
      chk("A.outs", {9'd0, seA, actA, hsA, vsA, xA, yA}, e.outs);
`ifdef VGA_FRAME_COUNT_EN
      chk("A.frameCount", 32'(fcA), 32'(e.fc));
`endif
    end
    if (qB.size() > 0) begin
      e = qB.pop_front();
      chk("B.outs", {9'd0, seB, actB, hsB, vsB, xB, yB}, e.outs);
`ifdef VGA_FRAME_COUNT_EN
      chk("B.frameCount", 32'(fcB), 32'(e.fc));
`endif
    end
  end

  // Frame-level observations on B
  int phase = 0;
  int seT0[$];
  int seT1[$];
  int vsCnt = 0, vsFirst = -1;
  always @(negedge clk) begin
    if (rstB) begin
      if (seB) begin
        if (phase == 0) seT0.push_back(tB);
        else            seT1.push_back(tB);
      end
      if (phase == 0 && !vsB && tB < 4400) begin
        vsCnt++;
        if (vsFirst < 0) vsFirst = tB;
      end
    end
  end

  initial begin
    int v;
    rstA = 1'b0;
    rstB = 1'b0;
    repeat (3) @(negedge clk);
    chk("A.reset", {9'd0, seA, actA, hsA, vsA, xA, yA},
        {9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 9'd0});
    rstA = 1'b1;
    rstB = 1'b1;

    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (k == 639) begin
        chk("A.x639", 32'(xA), 32'd639);
        chk("A.y639", 32'(yA), 32'd0);
      end
      if (k == 640) begin
        chk("A.act640", 32'(actA), 32'd0);
        chk("A.x640", 32'(xA), 32'd0);
      end
      if (k == 655) chk("A.hs655", 32'(hsA), 32'd1);
      if (k == 656) chk("A.hs656", 32'(hsA), 32'd0);
      if (k == 751) chk("A.hs751", 32'(hsA), 32'd0);
      if (k == 752) chk("A.hs752", 32'(hsA), 32'd1);
      if (k == 800) begin
        chk("A.y800", 32'(yA), 32'd1);
        chk("A.act800", 32'(actA), 32'd1);
      end
    end

    // B runs into its fourth frame; reset it at hCount=30, vCount=20
    while (tB < 14830) @(negedge clk);
`ifdef VGA_FRAME_COUNT_EN
    chk("B.fc3", 32'(fcB), 32'd3);
`endif
    rstB  = 1'b0;
    phase = 1;
    @(negedge clk);
    rstB = 1'b1;
    chk("B.rstMid", {9'd0, seB, actB, hsB, vsB, xB, yB},
        {9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 9'd0});
    while (tB < 3900) @(negedge clk);

    chk("B.seCount", 32'(seT0.size()), 32'd3);
    v = (seT0.size() > 0) ? seT0[0] : -1;
    chk("B.se1", 32'(v), 32'd3840);
    v = (seT0.size() > 1) ? seT0[1] : -1;
    chk("B.se2", 32'(v), 32'd8240);
    v = (seT0.size() > 2) ? seT0[2] : -1;
    chk("B.se3", 32'(v), 32'd12640);
    chk("B.vsLowCycles", 32'(vsCnt), 32'd160);
    chk("B.vsFirst", 32'(vsFirst), 32'd4000);
    chk("B.seAfterRst", 32'(seT1.size()), 32'd1);
    v = (seT1.size() > 0) ? seT1[0] : -1;
    chk("B.seAfterRstT", 32'(v), 32'd3840);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
